// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared types and helpers for the UART transmit feeder
package uart_pkg;

  localparam logic [2:0] DATA_BITS_5 = 3'd0;
  localparam logic [2:0] DATA_BITS_6 = 3'd1;
  localparam logic [2:0] DATA_BITS_7 = 3'd2;
  localparam logic [2:0] DATA_BITS_8 = 3'd3;
  localparam logic [2:0] DATA_BITS_9 = 3'd4;

  typedef enum logic [1:0] {IDLE, LAUNCH, WAIT_DONE} feeder_state_t;

  // Keeps the low 5+N bits; codes above DATA_BITS_9 saturate to a 9-bit frame.
  function automatic logic [31:0] data_mask(input logic [2:0] bits);
    logic [2:0] n;
    n = (bits > DATA_BITS_9) ? DATA_BITS_9 : bits;
    data_mask = (32'd1 << (32'd5 + 32'(n))) - 32'd1;
  endfunction

endpackage

// File: rtl/uart_sync_fifo.sv
// rtl/uart_sync_fifo.sv - single-clock word FIFO with flush, registered status and overflow pulse
module uart_sync_fifo #(
  parameter int DATA_WIDTH = 9,
  parameter int DEPTH      = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    i_push,
  input  logic [DATA_WIDTH-1:0]   i_data,
  input  logic                    i_pop,
  input  logic                    i_flush,
  output logic [DATA_WIDTH-1:0]   o_head,
  output logic                    o_full,
  output logic                    o_empty,
  output logic [$clog2(DEPTH):0]  o_count,
  output logic                    o_overflow
);

  localparam int AW = $clog2(DEPTH);

  logic [DATA_WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]         r_wr_ptr;
  logic [AW-1:0]         r_rd_ptr;
  logic [AW:0]           r_count;
  logic                  r_full;
  logic                  r_empty;
  logic                  r_overflow;
  logic                  w_push_ok;
  logic                  w_pop_ok;
  logic [AW:0]           w_count_nxt;

  assign w_push_ok = i_push & ~r_full & ~i_flush;
  assign w_pop_ok  = i_pop & ~r_empty;

  always_comb begin
    w_count_nxt = r_count;
    if (i_flush) begin
      w_count_nxt = '0;
    end else begin
      case ({w_push_ok, w_pop_ok})
        2'b10:   w_count_nxt = r_count + 1'b1;
        2'b01:   w_count_nxt = r_count - 1'b1;
        default: w_count_nxt = r_count;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
      r_full     <= 1'b0;
      r_empty    <= 1'b1;
      r_overflow <= 1'b0;
    end else begin
      r_count    <= w_count_nxt;
      r_full     <= (w_count_nxt == (AW+1)'(DEPTH));
      r_empty    <= (w_count_nxt == '0);
      // Fullness is judged on the registered flag, so a same-cycle pop cannot rescue the push.
      r_overflow <= i_push & r_full & ~i_flush;
      if (i_flush) begin
        r_wr_ptr <= '0;
        r_rd_ptr <= '0;
      end else begin
        if (w_push_ok) r_wr_ptr <= r_wr_ptr + 1'b1;
        if (w_pop_ok)  r_rd_ptr <= r_rd_ptr + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (w_push_ok) r_mem[r_wr_ptr] <= i_data;
  end

  assign o_head     = r_mem[r_rd_ptr];
  assign o_full     = r_full;
  assign o_empty    = r_empty;
  assign o_count    = r_count;
  assign o_overflow = r_overflow;

endmodule

// File: rtl/uart_tx_feeder.sv
// rtl/uart_tx_feeder.sv - buffers host words and launches them one at a time into a UART transmitter
module uart_tx_feeder
  import uart_pkg::*;
#(
  parameter int DATA_WIDTH    = 9,
  parameter int DEPTH         = 16,
  parameter int START_TIMEOUT = 65535
) (
  input  logic                    Clk_In,
  input  logic                    Reset_In,
  input  logic                    Wr_En_In,
  input  logic [DATA_WIDTH-1:0]   Wr_Data_In,
  input  logic                    Flush_In,
  input  logic [2:0]              Num_Data_Bits_In,
  input  logic                    UART_TX_Busy_In,
  output logic                    UART_Start_Signal_Out,
  output logic [DATA_WIDTH-1:0]   UART_Data_Out,
  output logic                    Full_Out,
  output logic                    Empty_Out,
  output logic [$clog2(DEPTH):0]  Count_Out,
  output logic                    Feeder_Busy_Out,
  output logic                    Overflow_Out,
  output logic                    Timeout_Out
);

  localparam logic [15:0] TMO_LAST = 16'(START_TIMEOUT - 1);

  feeder_state_t         r_state;
  logic                  r_start;
  logic [DATA_WIDTH-1:0] r_data;
  logic [15:0]           r_tcnt;
  logic                  r_timeout;
  logic                  r_fbusy;
  logic [DATA_WIDTH-1:0] w_head;
  logic [DATA_WIDTH-1:0] w_mask;
  logic                  w_empty;
  logic                  w_pop;

  assign w_mask = DATA_WIDTH'(data_mask(Num_Data_Bits_In));
  assign w_pop  = (r_state == IDLE) & ~w_empty & ~UART_TX_Busy_In;

  uart_sync_fifo #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (DEPTH)
  ) u_fifo (
    .clk        (Clk_In),
    .rst        (Reset_In),
    .i_push     (Wr_En_In),
    .i_data     (Wr_Data_In),
    .i_pop      (w_pop),
    .i_flush    (Flush_In),
    .o_head     (w_head),
    .o_full     (Full_Out),
    .o_empty    (w_empty),
    .o_count    (Count_Out),
    .o_overflow (Overflow_Out)
  );

  always_ff @(posedge Clk_In or posedge Reset_In) begin
    if (Reset_In) begin
      r_state   <= IDLE;
      r_start   <= 1'b0;
      r_data    <= '0;
      r_tcnt    <= '0;
      r_timeout <= 1'b0;
      r_fbusy   <= 1'b0;
    end else begin
      r_timeout <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_pop) begin
            r_data  <= w_head & w_mask;
            r_tcnt  <= '0;
            r_start <= 1'b1;
            r_fbusy <= 1'b1;
            r_state <= LAUNCH;
          end
        end
        LAUNCH: begin
          if (UART_TX_Busy_In) begin
            r_start <= 1'b0;
            r_state <= WAIT_DONE;
          end else if (r_tcnt == TMO_LAST) begin
            // UART never acknowledged: drop the word rather than stall the queue.
            r_start   <= 1'b0;
            r_timeout <= 1'b1;
            r_fbusy   <= 1'b0;
            r_state   <= IDLE;
          end else begin
            r_tcnt <= r_tcnt + 1'b1;
          end
        end
        WAIT_DONE: begin
          if (!UART_TX_Busy_In) begin
            r_fbusy <= 1'b0;
            r_state <= IDLE;
          end
        end
        default: begin
          r_start <= 1'b0;
          r_fbusy <= 1'b0;
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign UART_Start_Signal_Out = r_start;
  assign UART_Data_Out         = r_data;
  assign Empty_Out             = w_empty;
  assign Feeder_Busy_Out       = r_fbusy;
  assign Timeout_Out           = r_timeout;

endmodule

// File: tb/tb_uart_tx_feeder.sv
// tb/tb_uart_tx_feeder.sv - self-checking bench for uart_tx_feeder with a UART busy model and launch scoreboard
module tb_uart_tx_feeder;

  localparam int DW    = 9;
  localparam int DEPTH = 16;
  localparam int TMO   = 8;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          wr_en = 1'b0;
  logic [DW-1:0] wr_data = '0;
  logic          flush = 1'b0;
  logic [2:0]    nbits = 3'd3;
  logic          busy = 1'b0;
  logic          start;
  logic [DW-1:0] data_out;
  logic          full;
  logic          empty;
  logic [4:0]    count;
  logic          fbusy;
  logic          ovf;
  logic          tmo;

  always #5 clk = ~clk;

  uart_tx_feeder #(
    .DATA_WIDTH    (DW),
    .DEPTH         (DEPTH),
    .START_TIMEOUT (TMO)
  ) dut (
    .Clk_In                (clk),
    .Reset_In              (rst),
    .Wr_En_In              (wr_en),
    .Wr_Data_In            (wr_data),
    .Flush_In              (flush),
    .Num_Data_Bits_In      (nbits),
    .UART_TX_Busy_In       (busy),
    .UART_Start_Signal_Out (start),
    .UART_Data_Out         (data_out),
    .Full_Out              (full),
    .Empty_Out             (empty),
    .Count_Out             (count),
    .Feeder_Busy_Out       (fbusy),
    .Overflow_Out          (ovf),
    .Timeout_Out           (tmo)
  );

  int total = 0;
  int bad = 0;
  logic [DW-1:0] exp_q[$];
  logic [DW-1:0] mon_e;

  // mode 0: UART answers Start after 2 cycles and stays busy hold_len cycles; 1: busy stuck high; 2: stuck low
  int mode = 0;
  int hold_len = 4;
  int hold_cnt = 0;
  int dly = 0;
  int launches = 0;
  int width = 0;
  int ovf_cnt = 0;
  int tmo_cnt = 0;
  bit chk_width = 1'b1;
  int exp_width = 2;
  logic prev_start = 1'b0;

  typedef struct {
    logic [2:0]    bits;
    logic [DW-1:0] wd;
    logic [DW-1:0] exp;
  } vec_t;
  vec_t vecs[7];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic push(input logic [DW-1:0] d);
    wr_data = d;
    wr_en = 1'b1;
    @(negedge clk);
    wr_en = 1'b0;
  endtask

  task automatic wait_idle(input string nm);
    int n;
    n = 0;
    @(negedge clk);
    while (!(empty && !fbusy && !busy) && n < 400) begin
      @(negedge clk);
      n++;
    end
    total++;
    if (n >= 400) begin
      bad++;
      $display("FAIL %s: idle not reached within %0d cycles, required idle", nm, n);
    end
  endtask

  task automatic wait_tmo(input string nm);
    int n;
    n = 0;
    @(negedge clk);
    while (!tmo && n < 100) begin
      @(negedge clk);
      n++;
    end
    total++;
    if (n >= 100) begin
      bad++;
      $display("FAIL %s: no timeout pulse within %0d cycles, required a pulse", nm, n);
    end
  endtask

  always @(negedge clk) begin
    if (rst) begin
      prev_start = 1'b0;
      width = 0;
      dly = 0;
    end else begin
      if (start && !prev_start) begin
        launches++;
        width = 0;
        chk("launch_busy_low", busy, 0);
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_launch: got data %0h expected no launch", data_out);
        end else begin
          mon_e = exp_q.pop_front();
          chk("launch_data", data_out, mon_e);
        end
      end
      if (start) width++;
      if (!start && prev_start && chk_width) chk("start_width", width, exp_width);
      if (ovf) ovf_cnt++;
      if (tmo) tmo_cnt++;
      prev_start = start;
    end
    case (mode)
      1: busy = 1'b1;
      2: busy = 1'b0;
      default: begin
        if (!busy) begin
          if (start) begin
            dly++;
            if (dly == 2) begin
              busy = 1'b1;
              hold_cnt = hold_len;
              dly = 0;
            end
          end else begin
            dly = 0;
          end
        end else begin
          hold_cnt--;
          if (hold_cnt <= 0) busy = 1'b0;
        end
      end
    endcase
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int l0;
    int o0;
    int t0;
    int n;

    vecs[0] = '{3'd0, 9'h1FF, 9'h01F};
    vecs[1] = '{3'd7, 9'h1FF, 9'h1FF};
    vecs[2] = '{3'd1, 9'h1FF, 9'h03F};
    vecs[3] = '{3'd2, 9'h0AA, 9'h02A};
    vecs[4] = '{3'd3, 9'h1C3, 9'h0C3};
    vecs[5] = '{3'd4, 9'h1C3, 9'h1C3};
    vecs[6] = '{3'd5, 9'h155, 9'h155};

    // reset state
    repeat (3) @(negedge clk);
    chk("rst_start", start, 0);
    chk("rst_data", data_out, 0);
    chk("rst_full", full, 0);
    chk("rst_empty", empty, 1);
    chk("rst_count", count, 0);
    chk("rst_fbusy", fbusy, 0);
    chk("rst_ovf", ovf, 0);
    chk("rst_tmo", tmo, 0);
    rst = 1'b0;
    @(negedge clk);

    // two back-to-back words, 8-bit frames
    nbits = 3'd3;
    l0 = launches;
    exp_q.push_back(9'h0A5);
    exp_q.push_back(9'h0F3);
    push(9'h1A5);
    push(9'h0F3);
    wait_idle("t1");
    chk("t1_launches", launches, l0 + 2);
    chk("t1_last_data", data_out, 9'h0F3);

    // fill to full with the UART held busy, then one extra push
    mode = 1;
    repeat (2) @(negedge clk);
    o0 = ovf_cnt;
    for (int i = 0; i < 17; i++) push(9'(i + 16));
    repeat (2) @(negedge clk);
    chk("t2_count", count, 16);
    chk("t2_full", full, 1);
    chk("t2_empty", empty, 0);
    chk("t2_ovf_pulses", ovf_cnt - o0, 1);
    chk("t2_fbusy", fbusy, 0);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    @(negedge clk);
    chk("t2_flush_count", count, 0);
    chk("t2_flush_empty", empty, 1);
    chk("t2_flush_full", full, 0);

    // UART never raises busy: each launch aborts after TMO cycles
    nbits = 3'd4;
    exp_q.push_back(9'h123);
    exp_q.push_back(9'h0AB);
    push(9'h123);
    push(9'h0AB);
    repeat (2) @(negedge clk);
    chk("t3_count_pre", count, 2);
    exp_width = TMO;
    t0 = tmo_cnt;
    mode = 2;
    wait_tmo("t3_first");
    chk("t3_count_first", count, 1);
    chk("t3_start_off", start, 0);
    wait_tmo("t3_second");
    chk("t3_count_second", count, 0);
    chk("t3_empty", empty, 1);
    chk("t3_fbusy", fbusy, 0);
    @(negedge clk);
    chk("t3_tmo_pulses", tmo_cnt - t0, 2);
    mode = 0;
    exp_width = 2;
    repeat (2) @(negedge clk);

    // flush plus push while three words queued and one on the wire
    hold_len = 20;
    l0 = launches;
    exp_q.push_back(9'h011);
    push(9'h011);
    push(9'h022);
    push(9'h033);
    push(9'h044);
    chk("t4_queued", count, 3);
    chk("t4_inflight", fbusy, 1);
    o0 = ovf_cnt;
    wr_data = 9'h055;
    wr_en = 1'b1;
    flush = 1'b1;
    @(negedge clk);
    wr_en = 1'b0;
    flush = 1'b0;
    chk("t4_count", count, 0);
    chk("t4_empty", empty, 1);
    @(negedge clk);
    chk("t4_no_ovf", ovf_cnt - o0, 0);
    chk("t4_still_busy", fbusy, 1);
    wait_idle("t4");
    chk("t4_launches", launches, l0 + 1);
    chk("t4_data_kept", data_out, 9'h011);
    hold_len = 4;

    // asynchronous reset in the middle of a launch
    chk_width = 1'b0;
    mode = 2;
    repeat (2) @(negedge clk);
    exp_q.push_back(9'h155);
    push(9'h155);
    push(9'h0AA);
    n = 0;
    while (!start && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("t5_launching", start, 1);
    #2 rst = 1'b1;
    #1;
    chk("t5_start", start, 0);
    chk("t5_empty", empty, 1);
    chk("t5_count", count, 0);
    chk("t5_fbusy", fbusy, 0);
    chk("t5_data", data_out, 0);
    @(negedge clk);
    rst = 1'b0;
    mode = 0;
    repeat (2) @(negedge clk);
    chk_width = 1'b1;

    // frame-length masking, with the length input changed mid-launch
    for (int i = 0; i < 7; i++) begin
      nbits = vecs[i].bits;
      exp_q.push_back(vecs[i].exp);
      push(vecs[i].wd);
      n = 0;
      while (!fbusy && n < 20) begin
        @(negedge clk);
        n++;
      end
      nbits = 3'd0;
      wait_idle("vec");
      chk("vec_data", data_out, vecs[i].exp);
    end

    chk("scoreboard_empty", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
